// File: rtl/mat_rule_dispatcher.sv
// Match-action dispatcher: screens each parsed header against EtherType, a self-address
// filter and a first-match rule table scanned one entry per cycle, then hands out a decision.
module mat_rule_dispatcher #(
    parameter int AXIS_DEST_WIDTH = 2,
    parameter int NUM_RULES       = 4,
    parameter int RULE_ADDR_WIDTH = $clog2(NUM_RULES),
    parameter int HASH_FALLBACK   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                configurable_ipv4_address,
    input  logic [AXIS_DEST_WIDTH-1:0] default_dest,
    input  logic                       hdr_valid,
    output logic                       hdr_ready,
    input  logic [15:0]                hdr_ethtype,
    input  logic [31:0]                hdr_src_ipv4,
    input  logic                       rule_wr_en,
    output logic                       rule_wr_ready,
    input  logic [RULE_ADDR_WIDTH-1:0] rule_wr_addr,
    input  logic [66:0]                rule_wr_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic                       dec_drop,
    output logic [AXIS_DEST_WIDTH-1:0] dec_tdest,
    output logic [31:0]                pkt_count,
    output logic [31:0]                drop_count,
    output logic [31:0]                nomatch_count
);

    localparam logic [15:0] ETH_IPV4 = 16'h0800;
    localparam logic [RULE_ADDR_WIDTH-1:0] LAST_IDX = RULE_ADDR_WIDTH'(NUM_RULES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [AXIS_DEST_WIDTH-1:0] fit_dest(input logic [1:0] d);
        logic [AXIS_DEST_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < AXIS_DEST_WIDTH; i++) begin
            if (i < 2) v[i] = d[i[0]];
        end
        return v;
    endfunction

    state_t                      r_state, w_state_nxt;
    logic [RULE_ADDR_WIDTH-1:0]  r_idx, w_idx_nxt;
    logic                        r_out_en;
    logic [31:0]                 r_src;
    logic                        r_pend_drop;
    logic [AXIS_DEST_WIDTH-1:0]  r_pend_dest;
    logic                        r_nomatch;
    logic                        r_dec_valid, r_dec_drop;
    logic [AXIS_DEST_WIDTH-1:0]  r_dec_tdest;
    logic [31:0]                 r_pkt_count, r_drop_count, r_nomatch_count;

    logic                        r_rule_en   [NUM_RULES];
    logic                        r_rule_drop [NUM_RULES];
    logic [AXIS_DEST_WIDTH-1:0]  r_rule_dest [NUM_RULES];
    logic [31:0]                 r_rule_ip   [NUM_RULES];
    logic [31:0]                 r_rule_mask [NUM_RULES];

    logic                        w_hdr_xfer, w_dec_xfer, w_wr_fire, w_rule_hit;
    logic                        w_set_done, w_set_drop, w_set_nomatch;
    logic [AXIS_DEST_WIDTH-1:0]  w_set_dest, w_fallback_dest;

    assign hdr_ready     = r_out_en && (r_state == IDLE);
    assign rule_wr_ready = r_out_en && (r_state != SCAN);
    assign dec_valid     = r_dec_valid;
    assign dec_drop      = r_dec_drop;
    assign dec_tdest     = r_dec_tdest;
    assign pkt_count     = r_pkt_count;
    assign drop_count    = r_drop_count;
    assign nomatch_count = r_nomatch_count;

    assign w_hdr_xfer = hdr_valid && hdr_ready;
    assign w_dec_xfer = r_dec_valid && dec_ready;
    assign w_wr_fire  = rule_wr_en && rule_wr_ready
                        && (32'(rule_wr_addr) < 32'(NUM_RULES));

    assign w_rule_hit = r_rule_en[r_idx]
                        && ((r_src & r_rule_mask[r_idx]) == (r_rule_ip[r_idx] & r_rule_mask[r_idx]));
    assign w_fallback_dest = (HASH_FALLBACK != 0) ? r_src[AXIS_DEST_WIDTH-1:0] : default_dest;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_set_done    = 1'b0;
        w_set_drop    = 1'b0;
        w_set_dest    = '0;
        w_set_nomatch = 1'b0;
        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (w_hdr_xfer) begin
                    if (hdr_ethtype != ETH_IPV4) begin
                        w_state_nxt = DONE;
                        w_set_done  = 1'b1;
                        w_set_dest  = default_dest;
                    end else if (hdr_src_ipv4 == configurable_ipv4_address) begin
                        w_state_nxt = DONE;
                        w_set_done  = 1'b1;
                        w_set_drop  = 1'b1;
                        w_set_dest  = hdr_src_ipv4[AXIS_DEST_WIDTH-1:0];
                    end else begin
                        w_state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (w_rule_hit) begin
                    w_state_nxt = DONE;
                    w_set_done  = 1'b1;
                    w_set_drop  = r_rule_drop[r_idx];
                    w_set_dest  = r_rule_dest[r_idx];
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt   = DONE;
                    w_set_done    = 1'b1;
                    w_set_dest    = w_fallback_dest;
                    w_set_nomatch = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + RULE_ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                if (w_dec_xfer) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_out_en  <= 1'b0;
            r_nomatch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_out_en <= 1'b1;
            if (w_set_done) r_nomatch <= w_set_nomatch;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hdr_xfer) r_src <= hdr_src_ipv4;
        if (w_set_done) begin
            r_pend_drop <= w_set_drop;
            r_pend_dest <= w_set_dest;
        end
    end

    // Decision outputs trail the DONE state by one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_valid <= 1'b0;
            r_dec_drop  <= 1'b0;
            r_dec_tdest <= '0;
        end else if ((r_state == DONE) && !w_dec_xfer) begin
            r_dec_valid <= 1'b1;
            r_dec_drop  <= r_pend_drop;
            r_dec_tdest <= r_pend_dest;
        end else begin
            r_dec_valid <= 1'b0;
            r_dec_drop  <= 1'b0;
            r_dec_tdest <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count     <= '0;
            r_drop_count    <= '0;
            r_nomatch_count <= '0;
        end else if (w_dec_xfer) begin
            r_pkt_count <= sat_inc(r_pkt_count);
            if (r_dec_drop) r_drop_count    <= sat_inc(r_drop_count);
            if (r_nomatch)  r_nomatch_count <= sat_inc(r_nomatch_count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RULES; i++) r_rule_en[i] <= 1'b0;
        end else if (w_wr_fire) begin
            r_rule_en[rule_wr_addr] <= rule_wr_data[66];
        end
    end

    // Destination field sits at [64:63], sharing bit 63 with the top of the IP field.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_rule_drop[rule_wr_addr] <= rule_wr_data[65];
            r_rule_dest[rule_wr_addr] <= fit_dest(rule_wr_data[64:63]);
            r_rule_ip[rule_wr_addr]   <= rule_wr_data[63:32];
            r_rule_mask[rule_wr_addr] <= rule_wr_data[31:0];
        end
    end

endmodule

// File: tb/tb_mat_rule_dispatcher.sv
// Directed bench for mat_rule_dispatcher (default parameters: 2-bit dest, 4 rules, hash fallback).
module tb_mat_rule_dispatcher;

    logic        clk;
    logic        rst_n;
    logic [31:0] own_ip;
    logic [1:0]  default_dest;
    logic        hdr_valid, hdr_ready;
    logic [15:0] hdr_ethtype;
    logic [31:0] hdr_src_ipv4;
    logic        rule_wr_en, rule_wr_ready;
    logic [1:0]  rule_wr_addr;
    logic [66:0] rule_wr_data;
    logic        dec_valid, dec_ready, dec_drop;
    logic [1:0]  dec_tdest;
    logic [31:0] pkt_count, drop_count, nomatch_count;

    int n_pass  = 0;
    int n_total = 0;

    mat_rule_dispatcher dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .configurable_ipv4_address (own_ip),
        .default_dest              (default_dest),
        .hdr_valid                 (hdr_valid),
        .hdr_ready                 (hdr_ready),
        .hdr_ethtype               (hdr_ethtype),
        .hdr_src_ipv4              (hdr_src_ipv4),
        .rule_wr_en                (rule_wr_en),
        .rule_wr_ready             (rule_wr_ready),
        .rule_wr_addr              (rule_wr_addr),
        .rule_wr_data              (rule_wr_data),
        .dec_valid                 (dec_valid),
        .dec_ready                 (dec_ready),
        .dec_drop                  (dec_drop),
        .dec_tdest                 (dec_tdest),
        .pkt_count                 (pkt_count),
        .drop_count                (drop_count),
        .nomatch_count             (nomatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Rule word: dest low bit is bit 63, which is also ip[31].
    function automatic logic [66:0] rule_word(input logic en, input logic drop, input logic dhi,
                                              input logic [31:0] ip, input logic [31:0] mask);
        return {en, drop, dhi, ip, mask};
    endfunction

    task automatic send_hdr(input string tag, input logic [15:0] eth, input logic [31:0] src,
                            input bit do_wr, input logic [1:0] waddr, input logic [66:0] wdata,
                            input int exp_lat, input logic exp_drop, input logic [1:0] exp_dest);
        int lat;
        @(negedge clk);
        chk({tag, "_hdr_ready"}, hdr_ready, 1);
        hdr_valid    = 1'b1;
        hdr_ethtype  = eth;
        hdr_src_ipv4 = src;
        if (do_wr) begin
            rule_wr_en   = 1'b1;
            rule_wr_addr = waddr;
            rule_wr_data = wdata;
        end
        @(posedge clk);
        @(negedge clk);
        hdr_valid  = 1'b0;
        rule_wr_en = 1'b0;
        lat = 0;
        while (dec_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_drop"}, dec_drop, exp_drop);
        chk({tag, "_tdest"}, dec_tdest, exp_dest);
        chk({tag, "_hdr_ready_busy"}, hdr_ready, 0);
    endtask

    task automatic ack(input string tag);
        dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec_ready = 1'b0;
        chk({tag, "_valid_clr"}, dec_valid, 0);
        chk({tag, "_tdest_clr"}, dec_tdest, 0);
        chk({tag, "_hdr_ready_next"}, hdr_ready, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        own_ip       = 32'h0A00_0005;
        default_dest = 2'd3;
        hdr_valid    = 1'b0;
        hdr_ethtype  = 16'h0;
        hdr_src_ipv4 = 32'h0;
        rule_wr_en   = 1'b0;
        rule_wr_addr = 2'd0;
        rule_wr_data = '0;
        dec_ready    = 1'b0;

        #1;
        chk("rst_hdr_ready", hdr_ready, 0);
        chk("rst_wr_ready", rule_wr_ready, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_hdr_ready_pre_edge", hdr_ready, 0);
        @(negedge clk);
        chk("rel_hdr_ready", hdr_ready, 1);
        chk("rel_wr_ready", rule_wr_ready, 1);

        // Non-IPv4 goes straight to default_dest.
        send_hdr("ipv6", 16'h86DD, 32'h0102_0304, 0, 2'd0, '0, 1, 1'b0, 2'd3);
        ack("ipv6");
        chk("ipv6_pkt", pkt_count, 1);
        chk("ipv6_drop_cnt", drop_count, 0);

        // Self-filter.
        send_hdr("self", 16'h0800, 32'h0A00_0005, 0, 2'd0, '0, 1, 1'b1, 2'd1);
        ack("self");
        chk("self_drop_cnt", drop_count, 1);
        chk("self_pkt", pkt_count, 2);

        // Rule 2: 192.168.1.0/24 forward to dest 1.
        @(negedge clk);
        rule_wr_en   = 1'b1;
        rule_wr_addr = 2'd2;
        rule_wr_data = rule_word(1'b1, 1'b0, 1'b0, 32'hC0A8_0100, 32'hFFFF_FF00);
        @(posedge clk);
        @(negedge clk);
        rule_wr_en = 1'b0;
        send_hdr("r2", 16'h0800, 32'hC0A8_014D, 0, 2'd0, '0, 4, 1'b0, 2'd1);
        ack("r2");
        chk("r2_nomatch_cnt", nomatch_count, 0);

        // No match: hash fallback, held decision stays stable.
        send_hdr("nm", 16'h0800, 32'h0A01_020E, 0, 2'd0, '0, 5, 1'b0, 2'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nm_hold_valid", dec_valid, 1);
            chk("nm_hold_tdest", dec_tdest, 2);
            chk("nm_hold_drop", dec_drop, 0);
        end
        ack("nm");
        chk("nm_nomatch_cnt", nomatch_count, 1);
        chk("nm_pkt", pkt_count, 4);

        // Rule 0 drop 10.1.0.0/16 dest 2; rule 3 catch-all dest 3.
        @(negedge clk);
        rule_wr_en   = 1'b1;
        rule_wr_addr = 2'd0;
        rule_wr_data = rule_word(1'b1, 1'b1, 1'b1, 32'h0A01_0000, 32'hFFFF_0000);
        @(negedge clk);
        rule_wr_addr = 2'd3;
        rule_wr_data = rule_word(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000);
        @(negedge clk);
        rule_wr_en = 1'b0;
        send_hdr("r0", 16'h0800, 32'h0A01_020E, 0, 2'd0, '0, 2, 1'b1, 2'd2);
        ack("r0");
        chk("r0_drop_cnt", drop_count, 2);
        send_hdr("r3", 16'h0800, 32'h0101_0101, 0, 2'd0, '0, 5, 1'b0, 2'd3);
        ack("r3");
        chk("r3_nomatch_cnt", nomatch_count, 1);
        chk("r3_pkt", pkt_count, 6);

        // Rule 1 written on the same edge as the header transfer.
        send_hdr("wrsame", 16'h0800, 32'h0101_0101, 1, 2'd1,
                 rule_word(1'b1, 1'b1, 1'b0, 32'h0101_0100, 32'hFFFF_FF00), 3, 1'b1, 2'd0);
        ack("wrsame");
        chk("wrsame_drop_cnt", drop_count, 3);

        // Write during SCAN is held off until DONE; rule 1 still matches this packet.
        begin
            int lat;
            @(negedge clk);
            hdr_valid    = 1'b1;
            hdr_ethtype  = 16'h0800;
            hdr_src_ipv4 = 32'h0101_0101;
            @(posedge clk);
            @(negedge clk);
            hdr_valid    = 1'b0;
            rule_wr_en   = 1'b1;
            rule_wr_addr = 2'd1;
            rule_wr_data = '0;
            chk("defer_wr_ready_scan", rule_wr_ready, 0);
            lat = 0;
            while (dec_valid !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("defer_latency", 32'(lat), 3);
            chk("defer_drop", dec_drop, 1);
            chk("defer_wr_ready_done", rule_wr_ready, 1);
            rule_wr_en = 1'b0;
            force dut.r_drop_count = 32'hFFFF_FFFE;
            #1;
            release dut.r_drop_count;
            ack("defer");
            chk("sat_drop_cnt_max", drop_count, 32'hFFFF_FFFF);
        end
        send_hdr("sat", 16'h0800, 32'h0A00_0005, 0, 2'd0, '0, 1, 1'b1, 2'd1);
        ack("sat");
        chk("sat_drop_cnt_hold", drop_count, 32'hFFFF_FFFF);
        send_hdr("r1off", 16'h0800, 32'h0101_0101, 0, 2'd0, '0, 5, 1'b0, 2'd3);
        ack("r1off");
        chk("r1off_pkt", pkt_count, 10);
        chk("r1off_nomatch_cnt", nomatch_count, 1);

        // Reset pulsed mid-SCAN.
        @(negedge clk);
        hdr_valid    = 1'b1;
        hdr_ethtype  = 16'h0800;
        hdr_src_ipv4 = 32'h0202_0202;
        @(posedge clk);
        @(negedge clk);
        hdr_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_dec_valid", dec_valid, 0);
        chk("mrst_hdr_ready", hdr_ready, 0);
        chk("mrst_wr_ready", rule_wr_ready, 0);
        chk("mrst_pkt", pkt_count, 0);
        chk("mrst_drop_cnt", drop_count, 0);
        chk("mrst_nomatch_cnt", nomatch_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_hdr("post", 16'h0800, 32'h0101_0101, 0, 2'd0, '0, 5, 1'b0, 2'd1);
        ack("post");
        chk("post_pkt", pkt_count, 1);
        chk("post_nomatch_cnt", nomatch_count, 1);
        chk("post_drop_cnt", drop_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
